// File: rtl/hdmi_tx_csc_422.sv
// HDMI transmitter output stage: RGB888 to BT.601 limited-range YCbCr 4:2:2
// on a 16-bit bus, or RGB565 bypass, with timing delayed by a fixed 5 cycles.
module hdmi_tx_csc_422 #(
   parameter bit CR_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csc_enable,
   input  logic [23:0] vid_data,
   input  logic        vid_de,
   input  logic        vid_hs,
   input  logic        vid_vs,
   output logic [15:0] hdmi_data,
   output logic        hdmi_de,
   output logic        hdmi_hs,
   output logic        hdmi_vs
);

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic csc;
      logic ph;
   } ctl_t;

   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
   endfunction

   logic               phase_r;
   ctl_t               s1_ctl_r, s2_ctl_r, s3_ctl_r, s4_ctl_r;
   logic [23:0]        s1_rgb_r;
   logic signed [17:0] p_yr_r, p_yg_r, p_yb_r;
   logic signed [17:0] p_ur_r, p_ug_r, p_ub_r;
   logic signed [17:0] p_vr_r, p_vg_r, p_vb_r;
   logic [15:0]        s2_565_r, s3_565_r, s4_565_r;
   logic [7:0]         s3_y_r, s3_cb_r, s3_cr_r;
   logic [7:0]         s4_y_r, s4_cb_r, s4_cr_r;
   logic [7:0]         prev_c2_r;
   logic               prev_ok_r;
   logic signed [17:0] r_s, g_s, b_s;
   logic signed [17:0] y_sum_s, cb_sum_s, cr_sum_s;
   logic [7:0]         c1_own_s, c2_own_s, c1_next_s;
   logic [15:0]        out_s;

   // Operand extension and the rounded matrix sums for stage 3
   always_comb begin
      r_s      = $signed({10'd0, s1_rgb_r[23:16]});
      g_s      = $signed({10'd0, s1_rgb_r[15:8]});
      b_s      = $signed({10'd0, s1_rgb_r[7:0]});
      y_sum_s  = p_yr_r + p_yg_r + p_yb_r + 18'sd128;
      cb_sum_s = p_ub_r - p_ur_r - p_ug_r + 18'sd128;
      cr_sum_s = p_vr_r - p_vg_r - p_vb_r + 18'sd128;
   end

   // Stages 1-4: input capture with pair phase, products, offsets, pair hold
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_r  <= 1'b0;
         s1_ctl_r <= ctl_t'(5'd0);
         s2_ctl_r <= ctl_t'(5'd0);
         s3_ctl_r <= ctl_t'(5'd0);
         s4_ctl_r <= ctl_t'(5'd0);
         s1_rgb_r <= 24'd0;
         p_yr_r   <= 18'sd0;  p_yg_r <= 18'sd0;  p_yb_r <= 18'sd0;
         p_ur_r   <= 18'sd0;  p_ug_r <= 18'sd0;  p_ub_r <= 18'sd0;
         p_vr_r   <= 18'sd0;  p_vg_r <= 18'sd0;  p_vb_r <= 18'sd0;
         s2_565_r <= 16'd0;
         s3_565_r <= 16'd0;
         s4_565_r <= 16'd0;
         s3_y_r   <= 8'd0;  s3_cb_r <= 8'd0;  s3_cr_r <= 8'd0;
         s4_y_r   <= 8'd0;  s4_cb_r <= 8'd0;  s4_cr_r <= 8'd0;
      end else begin
         phase_r  <= vid_de ? ~phase_r : 1'b0;
         s1_rgb_r <= vid_data;
         s1_ctl_r <= {vid_de, vid_hs, vid_vs, csc_enable, phase_r & vid_de};

         p_yr_r   <= r_s * 18'sd66;
         p_yg_r   <= g_s * 18'sd129;
         p_yb_r   <= b_s * 18'sd25;
         p_ur_r   <= r_s * 18'sd38;
         p_ug_r   <= g_s * 18'sd74;
         p_ub_r   <= b_s * 18'sd112;
         p_vr_r   <= r_s * 18'sd112;
         p_vg_r   <= g_s * 18'sd94;
         p_vb_r   <= b_s * 18'sd18;
         s2_565_r <= {s1_rgb_r[23:19], s1_rgb_r[15:10], s1_rgb_r[7:3]};
         s2_ctl_r <= s1_ctl_r;

         s3_y_r   <= 8'((y_sum_s >>> 8) + 18'sd16);
         s3_cb_r  <= 8'((cb_sum_s >>> 8) + 18'sd128);
         s3_cr_r  <= 8'((cr_sum_s >>> 8) + 18'sd128);
         s3_565_r <= s2_565_r;
         s3_ctl_r <= s2_ctl_r;

         s4_y_r   <= s3_y_r;
         s4_cb_r  <= s3_cb_r;
         s4_cr_r  <= s3_cr_r;
         s4_565_r <= s3_565_r;
         s4_ctl_r <= s3_ctl_r;
      end
   end

   // Output word select; the even pixel looks ahead to stage 3, the odd one back
   always_comb begin
      out_s     = 16'h0000;
      c1_own_s  = CR_FIRST ? s4_cr_r : s4_cb_r;
      c2_own_s  = CR_FIRST ? s4_cb_r : s4_cr_r;
      c1_next_s = CR_FIRST ? s3_cr_r : s3_cb_r;
      if (!s4_ctl_r.de) begin
         out_s = 16'h0000;
      end else if (!s4_ctl_r.csc) begin
         out_s = s4_565_r;
      end else if (!s4_ctl_r.ph) begin
         if (s3_ctl_r.de && s3_ctl_r.csc) begin
            out_s = {avg8(c1_own_s, c1_next_s), s4_y_r};
         end else begin
            out_s = {c1_own_s, s4_y_r};
         end
      end else begin
         if (prev_ok_r) begin
            out_s = {avg8(prev_c2_r, c2_own_s), s4_y_r};
         end else begin
            out_s = {c2_own_s, s4_y_r};
         end
      end
   end

   // Stage 5: output register plus the previous pixel's second chroma
   always_ff @(posedge clk) begin
      if (rst) begin
         hdmi_data <= 16'h0000;
         hdmi_de   <= 1'b0;
         hdmi_hs   <= 1'b0;
         hdmi_vs   <= 1'b0;
         prev_c2_r <= 8'd0;
         prev_ok_r <= 1'b0;
      end else begin
         hdmi_data <= out_s;
         hdmi_de   <= s4_ctl_r.de;
         hdmi_hs   <= s4_ctl_r.hs;
         hdmi_vs   <= s4_ctl_r.vs;
         prev_c2_r <= c2_own_s;
         prev_ok_r <= s4_ctl_r.de && s4_ctl_r.csc;
      end
   end

endmodule

// File: tb/tb_hdmi_tx_csc_422.sv
// Bench for hdmi_tx_csc_422: directed lines through both chroma orders, with a
// behavioural model feeding a 5-deep scoreboard checked on the falling edge.
module tb_hdmi_tx_csc_422;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csc_enable = 1'b0;
   logic [23:0] vid_data = 24'd0;
   logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
   logic [15:0] hd0, hd1;
   logic        de0, hs0, vs0, de1, hs1, vs1;

   always #5 clk = ~clk;

   hdmi_tx_csc_422 #(.CR_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .csc_enable(csc_enable), .vid_data(vid_data),
      .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .hdmi_data(hd0), .hdmi_de(de0), .hdmi_hs(hs0), .hdmi_vs(vs0));

   hdmi_tx_csc_422 #(.CR_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .csc_enable(csc_enable), .vid_data(vid_data),
      .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .hdmi_data(hd1), .hdmi_de(de1), .hdmi_hs(hs1), .hdmi_vs(vs1));

   typedef struct packed {
      logic [23:0] d;
      logic        de, hs, vs, csc;
   } stim_t;

   typedef struct packed {
      logic [15:0] d0, d1;
      logic        de, hs, vs;
   } exp_t;

   stim_t seg[$];
   exp_t  sb[$];
   int    n_chk = 0;
   int    n_fail = 0;

   function automatic logic [7:0] m_y(input logic [23:0] p);
      int r, g, b;
      r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
      return 8'(((66*r + 129*g + 25*b + 128) >>> 8) + 16);
   endfunction

   function automatic logic [7:0] m_cb(input logic [23:0] p);
      int r, g, b;
      r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
      return 8'(((-38*r - 74*g + 112*b + 128) >>> 8) + 128);
   endfunction

   function automatic logic [7:0] m_cr(input logic [23:0] p);
      int r, g, b;
      r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
      return 8'(((112*r - 94*g - 18*b + 128) >>> 8) + 128);
   endfunction

   function automatic logic [7:0] m_avg(input logic [7:0] a, input logic [7:0] b);
      int s;
      s = (int'(a) + int'(b) + 1) / 2;
      return 8'(s);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, expv);
      end
   endtask

   task automatic add(input logic [23:0] d, input logic de, input logic hs,
                      input logic vs, input logic csc);
      stim_t s;
      s.d = d; s.de = de; s.hs = hs; s.vs = vs; s.csc = csc;
      seg.push_back(s);
   endtask

   task automatic idle(input int n, input logic hs, input logic vs);
      for (int k = 0; k < n; k++) add(24'd0, 1'b0, hs, vs, 1'b1);
   endtask

   task automatic cycle(input stim_t s, input exp_t e);
      exp_t o;
      @(negedge clk);
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL scoreboard_empty at %0t: observed=0 expected=5 entries", $time);
      end else begin
         o = sb.pop_front();
         chk("data_cb_first", hd0, o.d0);
         chk("data_cr_first", hd1, o.d1);
         chk("ctl_cb_first", {13'd0, de0, hs0, vs0}, {13'd0, o.de, o.hs, o.vs});
         chk("ctl_cr_first", {13'd0, de1, hs1, vs1}, {13'd0, o.de, o.hs, o.vs});
      end
      vid_data = s.d; vid_de = s.de; vid_hs = s.hs; vid_vs = s.vs; csc_enable = s.csc;
      sb.push_back(e);
   endtask

   // Compute expectations for the queued segment with pair lookahead, then drive it.
   task automatic run_seg();
      exp_t  ex[$];
      exp_t  e;
      int    ph;
      logic  paired;
      logic [7:0] y, cb, cr, cbx, crx;
      ph = 0;
      for (int i = 0; i < seg.size(); i++) begin
         e = '0;
         e.de = seg[i].de; e.hs = seg[i].hs; e.vs = seg[i].vs;
         if (seg[i].de) begin
            if (!seg[i].csc) begin
               e.d0 = {seg[i].d[23:19], seg[i].d[15:10], seg[i].d[7:3]};
               e.d1 = e.d0;
            end else begin
               y = m_y(seg[i].d); cb = m_cb(seg[i].d); cr = m_cr(seg[i].d);
               if (ph == 0) begin
                  paired = (i + 1 < seg.size()) && seg[i+1].de && seg[i+1].csc;
                  cbx = paired ? m_avg(cb, m_cb(seg[i+1].d)) : cb;
                  crx = paired ? m_avg(cr, m_cr(seg[i+1].d)) : cr;
                  e.d0 = {cbx, y};
                  e.d1 = {crx, y};
               end else begin
                  paired = (i > 0) && seg[i-1].de && seg[i-1].csc;
                  cbx = paired ? m_avg(m_cb(seg[i-1].d), cb) : cb;
                  crx = paired ? m_avg(m_cr(seg[i-1].d), cr) : cr;
                  e.d0 = {crx, y};
                  e.d1 = {cbx, y};
               end
            end
            ph = ph ^ 1;
         end else begin
            ph = 0;
         end
         ex.push_back(e);
      end
      for (int i = 0; i < seg.size(); i++) cycle(seg[i], ex[i]);
      seg.delete();
   endtask

   // Reset for one cycle while a pixel is being presented; pipeline contents are dropped.
   task automatic do_reset(input logic [23:0] d, input logic de);
      @(negedge clk);
      rst = 1'b1; vid_data = d; vid_de = de; vid_hs = 1'b1; vid_vs = 1'b1; csc_enable = 1'b1;
      @(negedge clk);
      chk("rst_data_cb_first", hd0, 16'h0000);
      chk("rst_data_cr_first", hd1, 16'h0000);
      chk("rst_ctl_cb_first", {13'd0, de0, hs0, vs0}, 16'h0000);
      chk("rst_ctl_cr_first", {13'd0, de1, hs1, vs1}, 16'h0000);
      rst = 1'b0; vid_data = 24'd0; vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0;
      sb.delete();
      for (int k = 0; k < 5; k++) sb.push_back('0);
   endtask

   initial begin
      do_reset(24'd0, 1'b0);

      // White then black 2-pixel lines, hs pulse in blanking
      add(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1); add(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b1, 1'b0);
      add(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1); add(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0, 1'b1);
      // Constant red line, then red/white pair
      for (int k = 0; k < 4; k++) add(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0, 1'b0);
      add(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b1); add(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0, 1'b0);
      // Three-pixel red line: unpaired last pixel
      for (int k = 0; k < 3; k++) add(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1, 1'b0);
      // Bypass line, then YCbCr line: format changes at the first pixel
      add(24'h123456, 1'b1, 1'b0, 1'b0, 1'b0); add(24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(24'h123456, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b1, 1'b1);
      add(24'h123456, 1'b1, 1'b0, 1'b0, 1'b1); add(24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0, 1'b0);
      // Mid-line mode change: even YCbCr then bypass is unpaired
      add(24'h00FF00, 1'b1, 1'b0, 1'b0, 1'b1); add(24'h0000FF, 1'b1, 1'b0, 1'b0, 1'b0);
      add(24'h808080, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0, 1'b0);
      // Random pixels, mixed sync activity
      for (int k = 0; k < 8; k++) add(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) add(24'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
      idle(3, 1'b0, 1'b0);
      run_seg();

      // Mid-line reset after an odd number of pixels
      for (int k = 0; k < 3; k++) add(24'h00FF00, 1'b1, 1'b0, 1'b0, 1'b1);
      run_seg();
      do_reset(24'h00FF00, 1'b1);
      for (int k = 0; k < 2; k++) add(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(7, 1'b0, 1'b0);
      run_seg();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
